// File: rtl/i2s_tx_sched.sv
// Transmit scheduler feeding the I2S TX FIFO push port from separate left/right sources.
// Keeps L/R pairing by inserting silence when a due source misses its slot timeout.
module i2s_tx_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int TMO_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic                  stereo_i,
  input  logic [TMO_WIDTH-1:0]  tmo_i,
  input  logic                  l_valid_i,
  output logic                  l_ready_o,
  input  logic [DATA_WIDTH-1:0] l_data_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic                  push_o,
  input  logic                  full_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  slot_o,
  output logic                  busy_o,
  output logic                  udr_o,
  output logic [CNT_WIDTH-1:0]  udr_cnt_o,
  output logic [31:0]           pair_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SLOT_L  = 2'd1,
    SLOT_R  = 2'd2,
    DRAIN_R = 2'd3
  } state_t;

  localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);

  state_t                 state;
  logic                   stereo_q;
  logic [TMO_WIDTH-1:0]   wait_cnt;
  logic [CNT_WIDTH-1:0]   udr_cnt;
  logic [31:0]            pair_cnt;

  logic in_slot;
  logic slot_r;
  logic cur_valid;
  logic src_push;
  logic tmo_hit;
  logic push;

  // Handshake is zero-latency: everything below is a function of state and live inputs.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_slot   = (state != IDLE);
    slot_r    = (state == SLOT_R) || (state == DRAIN_R);
    cur_valid = slot_r ? r_valid_i : l_valid_i;
    src_push  = in_slot && !flush_i && cur_valid && !full_i;
    // Compare as >= so lowering tmo_i below the elapsed wait fires on the next eligible cycle.
    tmo_hit   = in_slot && !flush_i && (tmo_i != '0) && !cur_valid && !full_i &&
                (wait_cnt >= (tmo_i - TMO_ONE));
    push      = src_push || tmo_hit;

    l_ready_o = (state == SLOT_L) && !flush_i && !full_i && !tmo_hit;
    r_ready_o = slot_r && !flush_i && !full_i && !tmo_hit;
    push_o    = push;
    udr_o     = tmo_hit;
    slot_o    = slot_r;
    busy_o    = in_slot;
    dat_o     = '0;
    if (in_slot && !tmo_hit) begin
      dat_o = slot_r ? r_data_i : l_data_i;
    end
  end

  assign udr_cnt_o  = udr_cnt;
  assign pair_cnt_o = pair_cnt;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      stereo_q <= 1'b0;
      wait_cnt <= '0;
      udr_cnt  <= '0;
      pair_cnt <= '0;
    end else if (flush_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      udr_cnt  <= '0;
      pair_cnt <= '0;
    end else begin
      if (tmo_hit && (udr_cnt != '1)) begin
        udr_cnt <= udr_cnt + CNT_WIDTH'(1);
      end

      // Back-pressure holds the counter, so a full FIFO never causes a silence insertion.
      if (push) begin
        wait_cnt <= '0;
      end else if (in_slot && !cur_valid && !full_i && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + TMO_ONE;
      end

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (en_i) begin
            state    <= SLOT_L;
            stereo_q <= stereo_i;
          end
        end
        SLOT_L: begin
          if (push) begin
            if (stereo_q) begin
              state <= en_i ? SLOT_R : DRAIN_R;
            end else begin
              pair_cnt <= pair_cnt + 32'd1;
              if (!en_i) state <= IDLE;
            end
          end else if (!en_i) begin
            state <= IDLE;
          end
        end
        SLOT_R: begin
          // A disable without a right push drains so the pair is never left half-written.
          if (push) begin
            pair_cnt <= pair_cnt + 32'd1;
            state    <= en_i ? SLOT_L : IDLE;
          end else if (!en_i) begin
            state <= DRAIN_R;
          end
        end
        DRAIN_R: begin
          if (push) begin
            pair_cnt <= pair_cnt + 32'd1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
